// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control unit: Moore FSM sequencing fetch, decode and
// per-opcode execute states, with datapath controls decoded from the state register.
module mc_control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e     r_state;
  state_e     w_next;
  logic       w_supported;
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_mem_to_reg;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_instr_done;

  always_comb begin
    w_supported = (opcode == OP_RTYPE) || (opcode == OP_J)  || (opcode == OP_BEQ) ||
                  (opcode == OP_ADDI)  || (opcode == OP_LW) || (opcode == OP_SW);
  end

  // Opcode is only looked at in DECODE and MEMADR, so it may change freely elsewhere.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDIEX;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    w_instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_ir_write  = 1'b1;
        w_alu_src_b = 2'b01;
        w_pc_write  = 1'b1;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = 1'b1;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_source     = 2'b01;
        w_pc_write_cond = 1'b1;
        w_instr_done    = 1'b1;
      end
      S_JUMP: begin
        w_pc_source  = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset masks all controls immediately so no PC, IR, register or memory write
  // can slip through while rst_n is low; state stays visible for debug.
  assign pc_en      = rst_n & (w_pc_write | (w_pc_write_cond & zero));
  assign illegal_op = rst_n & (r_state == S_DECODE) & ~w_supported;
  assign iord       = rst_n & w_iord;
  assign mem_read   = rst_n & w_mem_read;
  assign mem_write  = rst_n & w_mem_write;
  assign ir_write   = rst_n & w_ir_write;
  assign mem_to_reg = rst_n & w_mem_to_reg;
  assign reg_write  = rst_n & w_reg_write;
  assign reg_dst    = rst_n & w_reg_dst;
  assign alu_src_a  = rst_n & w_alu_src_a;
  assign alu_src_b  = rst_n ? w_alu_src_b : 2'b00;
  assign alu_op     = rst_n ? w_alu_op    : 2'b00;
  assign pc_source  = rst_n ? w_pc_source : 2'b00;
  assign instr_done = rst_n & w_instr_done;
  assign state      = r_state;

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: opcode  input  6  instruction[31:26], taken from the instruction register.
REQ-004 SHALL have port: zero  input  1  ALU zero flag, used in BRANCH only.
REQ-005 SHALL have ports, all output 1 bit: pc_en (PC load), iord (memory address select, 1=ALUOut), mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst (1=rd), alu_src_a (1=register A).
REQ-006 SHALL have ports, all output 2 bits: alu_src_b (00=B, 01=const 4, 10=sign-extended imm, 11=imm<<2), alu_op (feeds ALU control unit: 00 add, 01 sub, 10 funct-decoded), pc_source (00=ALU result, 01=ALUOut, 10=jump target).
REQ-007 SHALL have port: instr_done  output  1  pulse in an instruction's final state.
REQ-008 SHALL have port: illegal_op  output  1  pulse in DECODE for an unsupported opcode.
REQ-009 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-010 SHALL implement a Moore FSM with a 4-bit state register: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-011 SHALL decode all outputs combinationally from the state register only, except pc_en and illegal_op.
REQ-012 SHALL drive 0 on every output not listed for the current state.
REQ-013 FETCH: mem_read=1, ir_write=1, alu_src_b=01, pc_write=1; next state DECODE.
REQ-014 DECODE: alu_src_b=11; next state by opcode:
  - 100011 (lw) and 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDIEX
  - any other opcode -> FETCH, with illegal_op=1 for that cycle
REQ-015 MEMADR: alu_src_a=1, alu_src_b=10; next state MEMRD if opcode=100011, otherwise MEMWR.
REQ-016 MEMRD: mem_read=1, iord=1; next state MEMWB.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1, instr_done=1; next state FETCH.
REQ-018 MEMWR: mem_write=1, iord=1, instr_done=1; next state FETCH.
REQ-019 EXEC: alu_src_a=1, alu_op=10; next state ALUWB.
REQ-020 ALUWB: reg_write=1, reg_dst=1, instr_done=1; next state FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond=1, instr_done=1; next state FETCH.
REQ-022 JUMP: pc_source=10, pc_write=1, instr_done=1; next state FETCH.
REQ-023 ADDIEX: alu_src_a=1, alu_src_b=10; next state ADDIWB.
REQ-024 ADDIWB: reg_write=1, instr_done=1; next state FETCH.
REQ-025 pc_en SHALL equal pc_write OR (pc_write_cond AND zero); pc_write and pc_write_cond are internal signals only.
REQ-026 Instruction latency in cycles, counted from FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-027 opcode SHALL be sampled in DECODE and MEMADR only; changes in other states SHALL have no effect.
REQ-028 An unreachable state encoding (12-15) SHALL go to FETCH on the next edge, with all outputs 0 while in it.

Reset
REQ-029 When rst_n=0 at a rising edge, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-030 While rst_n=0, every output except state SHALL be forced to 0 combinationally, so that no PC, IR, register or memory write occurs during reset.
REQ-031 On the first edge with rst_n=1, the FSM SHALL execute FETCH normally.

Verification
REQ-032 Bench: reset, release, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 in state 4; instr_done high exactly 1 cycle.
REQ-033 Bench: opcode=000100 with zero=1 -> pc_en=1 in BRANCH with pc_source=01; repeat with zero=0 -> pc_en=0 in BRANCH.
REQ-034 Bench: opcode=000000 -> alu_op=10 in EXEC; reg_dst=1 and reg_write=1 in ALUWB; returns to FETCH after 4 cycles.
REQ-035 Bench: opcode=111111 -> illegal_op=1 in DECODE, next state FETCH, no reg_write or mem_write asserted.
REQ-036 Bench: rst_n=0 asserted while in MEMRD -> all outputs 0 in that cycle; state=0 after the edge; FETCH outputs appear after release.
REQ-037 Bench: opcode changed from 101011 to 100011 during MEMWR -> still returns to FETCH; mem_write high only in MEMWR.
